// File: rtl/sdram_port_arbiter.sv
// Round-robin Avalon-MM arbiter in front of the SDRAM controller with read-ID tracking.
// Define VGA_PRIORITY_EN to let master 0 (VGA reader) pre-empt round-robin.
module sdram_port_arbiter #(
  parameter int NREQ     = 3,
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ*ADDR_W-1:0]   m_address,
  input  logic [NREQ-1:0]          m_read,
  input  logic [NREQ-1:0]          m_write,
  input  logic [NREQ*DATA_W-1:0]   m_writedata,
  input  logic [NREQ*DATA_W/8-1:0] m_byteenable,
  output logic [NREQ-1:0]          m_waitrequest,
  output logic [DATA_W-1:0]        m_readdata,
  output logic [NREQ-1:0]          m_readdatavalid,
  output logic [ADDR_W-1:0]        s_address,
  output logic                     s_read,
  output logic                     s_write,
  output logic [DATA_W-1:0]        s_writedata,
  output logic [DATA_W/8-1:0]      s_byteenable,
  input  logic                     s_waitrequest,
  input  logic [DATA_W-1:0]        s_readdata,
  input  logic                     s_readdatavalid,
  output logic                     err_orphan
);

  localparam int BE_W = DATA_W / 8;
  localparam int GW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW   = $clog2(MAX_PEND);
  localparam int CW   = PW + 1;
  localparam int HW   = $clog2(MAX_HOLD) + 1;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  state_t          state;
  logic [GW-1:0]   grant;
  logic [GW-1:0]   last;
  logic [HW-1:0]   hold;
  logic [GW-1:0]   nxt;

  logic [GW-1:0]   fifo [MAX_PEND];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic [CW-1:0]   count;

  logic [NREQ-1:0] req;
  logic            in_grant;
  logic            g_read;
  logic            g_write;
  logic            fifo_full;
  logic            rd_block;
  logic            accept;
  logic            push;
  logic            pop;
  logic            last_xfer;
  logic            vga_cut;
  logic            leave;

  assign req       = m_read | m_write;
  assign in_grant  = (state == GRANT);
  assign g_read    = m_read[grant];
  assign g_write   = m_write[grant];
  assign fifo_full = (count == CW'(MAX_PEND));
  assign rd_block  = g_read & fifo_full;

  assign s_address    = m_address[grant*ADDR_W +: ADDR_W];
  assign s_writedata  = m_writedata[grant*DATA_W +: DATA_W];
  assign s_byteenable = m_byteenable[grant*BE_W +: BE_W];
  assign s_read       = in_grant & g_read & ~fifo_full;
  assign s_write      = in_grant & g_write;
  assign m_readdata   = s_readdata;

  assign accept    = (s_read | s_write) & ~s_waitrequest;
  assign push      = accept & s_read;
  assign pop       = s_readdatavalid & (count != '0);
  assign last_xfer = accept & (hold == HW'(MAX_HOLD - 1));

`ifdef VGA_PRIORITY_EN
  assign vga_cut = accept & req[0] & (grant != '0);
`else
  assign vga_cut = 1'b0;
`endif

  assign leave = ~req[grant] | last_xfer | vga_cut;

  // First requester after the last grant, wrapping around.
  always_comb begin
    nxt = last;
    for (int k = NREQ; k >= 1; k--) begin
      if (req[(int'(last) + k) % NREQ])
        nxt = GW'((int'(last) + k) % NREQ);
    end
`ifdef VGA_PRIORITY_EN
    if (req[0])
      nxt = '0;
`endif
  end

  always_comb begin
    m_waitrequest = '1;
    if (in_grant)
      m_waitrequest[grant] = s_waitrequest | rd_block;
  end

  always_comb begin
    m_readdatavalid = '0;
    if (pop)
      m_readdatavalid[fifo[rptr]] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      last  <= GW'(NREQ - 1);
      hold  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req) begin
            grant <= nxt;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (leave) begin
            state <= IDLE;
            last  <= grant;
            hold  <= '0;
          end else if (accept) begin
            hold <= hold + HW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      fifo[wptr] <= grant;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      err_orphan <= 1'b0;
    end else begin
      if (push)
        wptr <= wptr + PW'(1);
      if (pop)
        rptr <= rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (s_readdatavalid && count == '0)
        err_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: master drivers, SDRAM slave model, read scoreboard.
module tb_sdram_port_arbiter;

  localparam int NREQ = 3;
  localparam int AW   = 25;
  localparam int DW   = 16;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ*AW-1:0]   m_address;
  logic [NREQ-1:0]      m_read;
  logic [NREQ-1:0]      m_write;
  logic [NREQ*DW-1:0]   m_writedata;
  logic [NREQ*DW/8-1:0] m_byteenable;
  logic [NREQ-1:0]      m_waitrequest;
  logic [DW-1:0]        m_readdata;
  logic [NREQ-1:0]      m_readdatavalid;
  logic [AW-1:0]        s_address;
  logic                 s_read;
  logic                 s_write;
  logic [DW-1:0]        s_writedata;
  logic [DW/8-1:0]      s_byteenable;
  logic                 s_waitrequest = 1'b0;
  logic [DW-1:0]        s_readdata = '0;
  logic                 s_readdatavalid = 1'b0;
  logic                 err_orphan;

  logic [AW-1:0] addr_a [NREQ];
  logic          rd_a   [NREQ];
  logic          wr_a   [NREQ];
  logic [DW-1:0] wd_a   [NREQ];

  typedef struct packed {
    logic [2:0]    oh;
    logic [DW-1:0] d;
  } ret_t;

  typedef struct {
    int            due;
    logic [DW-1:0] d;
  } pend_t;

  ret_t          exp_q [$];
  ret_t          got_q [$];
  int            acc_idx [$];
  int            acc_cyc [$];
  pend_t         rq [$];
  logic [DW-1:0] wmem [logic [AW-1:0]];
  int            cyc = 0;
  int            lat = 5;
  int            first_rdv = -1;
  logic          inj_rdv = 1'b0;
  int            checks = 0;
  int            errors = 0;

  sdram_port_arbiter dut (
    .clk             (clk),
    .reset           (reset),
    .m_address       (m_address),
    .m_read          (m_read),
    .m_write         (m_write),
    .m_writedata     (m_writedata),
    .m_byteenable    (m_byteenable),
    .m_waitrequest   (m_waitrequest),
    .m_readdata      (m_readdata),
    .m_readdatavalid (m_readdatavalid),
    .s_address       (s_address),
    .s_read          (s_read),
    .s_write         (s_write),
    .s_writedata     (s_writedata),
    .s_byteenable    (s_byteenable),
    .s_waitrequest   (s_waitrequest),
    .s_readdata      (s_readdata),
    .s_readdatavalid (s_readdatavalid),
    .err_orphan      (err_orphan)
  );

  always #5 clk = ~clk;

  assign m_byteenable = '1;

  always_comb begin
    m_address   = '0;
    m_read      = '0;
    m_write     = '0;
    m_writedata = '0;
    for (int i = 0; i < NREQ; i++) begin
      m_address[i*AW +: AW]   = addr_a[i];
      m_read[i]               = rd_a[i];
      m_write[i]              = wr_a[i];
      m_writedata[i*DW +: DW] = wd_a[i];
    end
  end

  function automatic logic [DW-1:0] rd_model(input logic [AW-1:0] a);
    if (wmem.exists(a))
      return wmem[a];
    return a[15:0] ^ 16'hA5C3;
  endfunction

  // SDRAM slave: accepts at the edge, returns read data lat cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        rq.delete();
      end else begin
        if (s_read && !s_waitrequest)
          rq.push_back('{due: cyc + lat, d: rd_model(s_address)});
        if (s_write && !s_waitrequest)
          wmem[s_address] = s_writedata;
      end
      @(posedge clk);
      cyc++;
      #1;
      if (rq.size() > 0 && rq[0].due <= cyc && !reset) begin
        s_readdatavalid = 1'b1;
        s_readdata      = rq[0].d;
        void'(rq.pop_front());
      end else begin
        s_readdatavalid = inj_rdv;
        s_readdata      = 16'hDEAD;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && |m_readdatavalid) begin
        if (first_rdv < 0)
          first_rdv = cyc;
        got_q.push_back({m_readdatavalid, m_readdata});
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    for (int i = 0; i < NREQ; i++) begin
      addr_a[i] = '0;
      rd_a[i]   = 1'b0;
      wr_a[i]   = 1'b0;
      wd_a[i]   = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    inj_rdv       = 1'b0;
    s_waitrequest = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    got_q.delete();
    acc_idx.delete();
    acc_cyc.delete();
    wmem.delete();
    first_rdv = -1;
    reset     = 1'b0;
  endtask

  task automatic xfer(input int i, input bit wr, input int n,
                      input logic [AW-1:0] base);
    for (int t = 0; t < n; t++) begin
      bit ok;
      addr_a[i] = base + AW'(t);
      wd_a[i]   = 16'h1000 + 16'(i * 256 + t);
      rd_a[i]   = !wr;
      wr_a[i]   = wr;
      ok = 1'b0;
      for (int w = 0; w < 300 && !ok; w++) begin
        @(negedge clk);
        if (!m_waitrequest[i]) begin
          ok = 1'b1;
          acc_idx.push_back(i);
          acc_cyc.push_back(cyc);
          if (!wr)
            exp_q.push_back({3'(1 << i), rd_model(addr_a[i])});
        end
        @(posedge clk);
        #1;
      end
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL xfer_timeout m%0d waitrequest=1 required 0", i);
        rd_a[i] = 1'b0;
        wr_a[i] = 1'b0;
        return;
      end
    end
    rd_a[i] = 1'b0;
    wr_a[i] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < NREQ; i++) rd_a[i] = 1'b1;
    @(negedge clk);
    checks++;
    if (m_waitrequest !== 3'b111) begin
      errors++;
      $display("FAIL rst_waitreq got %b need 111", m_waitrequest);
    end
    checks++;
    if (s_read !== 1'b0 || s_write !== 1'b0) begin
      errors++;
      $display("FAIL rst_srw got %b%b need 00", s_read, s_write);
    end
    checks++;
    if (m_readdatavalid !== 3'b000) begin
      errors++;
      $display("FAIL rst_rdv got %b need 000", m_readdatavalid);
    end
    checks++;
    if (err_orphan !== 1'b0) begin
      errors++;
      $display("FAIL rst_orphan got %b need 0", err_orphan);
    end
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    wr_a[1]   = 1'b1;
    addr_a[1] = 25'h100;
    wd_a[1]   = 16'hBEEF;
    @(negedge clk);
    checks++;
    if (s_write !== 1'b0 || m_waitrequest !== 3'b111) begin
      errors++;
      $display("FAIL wr_c0 got s_write=%b wreq=%b need 0 111",
               s_write, m_waitrequest);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (s_write !== 1'b1 || m_waitrequest !== 3'b101) begin
      errors++;
      $display("FAIL wr_c1 got s_write=%b wreq=%b need 1 101",
               s_write, m_waitrequest);
    end
    checks++;
    if (s_address !== 25'h100 || s_writedata !== 16'hBEEF) begin
      errors++;
      $display("FAIL wr_bus got %h/%h need 100/beef", s_address, s_writedata);
    end
    @(posedge clk);
    #1;
    wr_a[1] = 1'b0;
    @(negedge clk);
    checks++;
    if (s_write !== 1'b0) begin
      errors++;
      $display("FAIL wr_once got s_write=%b need 0", s_write);
    end
    checks++;
    if (!wmem.exists(25'h100) || wmem[25'h100] !== 16'hBEEF) begin
      errors++;
      $display("FAIL wr_mem got %h need beef", rd_model(25'h100));
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    lat = 5;
    fork
      xfer(0, 1'b0, 8, 25'h1000);
      xfer(1, 1'b0, 8, 25'h2000);
      xfer(2, 1'b0, 8, 25'h3000);
    join
    for (int w = 0; w < 100 && got_q.size() < exp_q.size(); w++)
      @(negedge clk);
    checks++;
    if (acc_idx.size() != 24) begin
      errors++;
      $display("FAIL rr_count got %0d need 24", acc_idx.size());
    end
    for (int k = 0; k < acc_idx.size() && k < 24; k++) begin
      checks++;
      if (acc_idx[k] != (k / 4) % 3) begin
        errors++;
        $display("FAIL rr_grant[%0d] got %0d need %0d",
                 k, acc_idx[k], (k / 4) % 3);
      end
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rr_sb_size got %0d need %0d", got_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      ret_t e = exp_q.pop_front();
      ret_t g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL rr_sb got %b/%h need %b/%h", g.oh, g.d, e.oh, e.d);
      end
    end
  endtask

  task automatic test_fifo_full();
    int early;
    do_reset();
    lat = 20;
    xfer(2, 1'b0, 12, 25'h4000);
    for (int w = 0; w < 200 && got_q.size() < exp_q.size(); w++)
      @(negedge clk);
    early = 0;
    foreach (acc_cyc[k])
      if (first_rdv >= 0 && acc_cyc[k] <= first_rdv)
        early++;
    checks++;
    if (first_rdv < 0 || early != 8) begin
      errors++;
      $display("FAIL ff_block got %0d accepts before first return need 8",
               early);
    end
    checks++;
    if (got_q.size() != 12 || exp_q.size() != 12) begin
      errors++;
      $display("FAIL ff_sb_size got %0d need 12", got_q.size());
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      ret_t e = exp_q.pop_front();
      ret_t g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL ff_sb got %b/%h need %b/%h", g.oh, g.d, e.oh, e.d);
      end
    end
    lat = 5;
  endtask

  task automatic test_interleave();
    do_reset();
    lat = 5;
    fork
      xfer(0, 1'b0, 3, 25'h5000);
      xfer(1, 1'b0, 3, 25'h6000);
    join
    for (int w = 0; w < 100 && got_q.size() < exp_q.size(); w++)
      @(negedge clk);
    checks++;
    if (got_q.size() != 6 || exp_q.size() != 6) begin
      errors++;
      $display("FAIL il_sb_size got %0d need 6", got_q.size());
    end
    checks++;
    if (got_q.size() > 0 && got_q[0].oh !== 3'b001) begin
      errors++;
      $display("FAIL il_first got %b need 001", got_q[0].oh);
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      ret_t e = exp_q.pop_front();
      ret_t g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL il_sb got %b/%h need %b/%h", g.oh, g.d, e.oh, e.d);
      end
    end
  endtask

  task automatic test_orphan_reset();
    do_reset();
    @(negedge clk);
    inj_rdv = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (m_readdatavalid !== 3'b000) begin
      errors++;
      $display("FAIL orph_strobe got %b need 000", m_readdatavalid);
    end
    inj_rdv = 1'b0;
    @(negedge clk);
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++;
      $display("FAIL orph_flag got %b need 1", err_orphan);
    end
    s_waitrequest = 1'b1;
    @(posedge clk);
    #1;
    wr_a[0]   = 1'b1;
    addr_a[0] = 25'h42;
    @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (s_write !== 1'b1 || m_waitrequest !== 3'b111) begin
      errors++;
      $display("FAIL mid_grant got s_write=%b wreq=%b need 1 111",
               s_write, m_waitrequest);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (m_waitrequest !== 3'b111 || s_write !== 1'b0 || s_read !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got wreq=%b rw=%b%b need 111 00",
               m_waitrequest, s_read, s_write);
    end
    checks++;
    if (err_orphan !== 1'b0 || m_readdatavalid !== 3'b000) begin
      errors++;
      $display("FAIL mid_rst_flags got %b/%b need 0/000",
               err_orphan, m_readdatavalid);
    end
    do_reset();
  endtask

  task automatic test_vga_priority();
    int exp_log [8];
`ifdef VGA_PRIORITY_EN
    exp_log = '{1, 1, 0, 0, 1, 1, 1, 1};
`else
    exp_log = '{1, 1, 1, 1, 0, 0, 1, 1};
`endif
    do_reset();
    fork
      xfer(1, 1'b1, 6, 25'h7000);
      begin
        for (int w = 0; w < 50; w++) begin
          @(posedge clk);
          #1;
          if (acc_idx.size() >= 1) break;
        end
        xfer(0, 1'b1, 2, 25'h7100);
      end
    join
    checks++;
    if (acc_idx.size() != 8) begin
      errors++;
      $display("FAIL vga_count got %0d need 8", acc_idx.size());
    end
    for (int k = 0; k < 8 && k < acc_idx.size(); k++) begin
      checks++;
      if (acc_idx[k] != exp_log[k]) begin
        errors++;
        $display("FAIL vga_grant[%0d] got %0d need %0d",
                 k, acc_idx[k], exp_log[k]);
      end
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_round_robin();
    test_fifo_full();
    test_interleave();
    test_orphan_reset();
    test_vga_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
